// File: rtl/nanorv32_datamem_resp_pkg.sv
// Shared widths, FSM encodings and request payload for the nanorv32 data memory responder.
package nanorv32_datamem_resp_pkg;

    localparam int unsigned NRV32_ADDR_MSB = 31;
    localparam int unsigned NRV32_DATA_MSB = 31;
    localparam int unsigned NRV32_ADDR_W   = NRV32_ADDR_MSB + 1;
    localparam int unsigned NRV32_DATA_W   = NRV32_DATA_MSB + 1;
    localparam int unsigned NRV32_BSEL_W   = 4;
    localparam int unsigned DMR_CNT_W      = 4;

    typedef enum logic [1:0] {
        NRV32_DMR_IDLE = 2'd0,
        NRV32_DMR_WAIT = 2'd1,
        NRV32_DMR_RESP = 2'd2
    } dmr_state_e;

    typedef struct packed {
        logic [NRV32_ADDR_W-1:0] addr;
        logic [NRV32_DATA_W-1:0] wdata;
        logic [NRV32_BSEL_W-1:0] bytesel;
    } dmr_req_t;

endpackage

// File: rtl/nanorv32_datamem_resp_ram_1p.sv
// Single-port synchronous RAM with byte-lane write enables and registered read.
module nanorv32_ram_1p
    import nanorv32_datamem_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic [NRV32_BSEL_W-1:0] we,
    input  logic [AW-1:0]           addr,
    input  logic [NRV32_DATA_W-1:0] wdata,
    output logic [NRV32_DATA_W-1:0] rdata
);

    logic [NRV32_DATA_W-1:0] mem [DEPTH];

    // Read-before-write; the responder only consumes rdata for reads.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < int'(NRV32_BSEL_W); i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/nanorv32_datamem_resp.sv
// Memory-side responder for the nanorv32 data port: wait-state FSM, range decode and RAM.
module nanorv32_datamem_resp
    import nanorv32_datamem_resp_pkg::*;
#(
    parameter int unsigned            MEM_DEPTH_WORDS = 1024,
    parameter int unsigned            WAIT_STATES     = 0,
    parameter logic [NRV32_ADDR_W-1:0] BASE_ADDR      = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NRV32_ADDR_W-1:0] cpu_datamem_addr,
    input  logic [NRV32_DATA_W-1:0] cpu_datamem_wdata,
    input  logic [NRV32_BSEL_W-1:0] cpu_datamem_bytesel,
    input  logic                    cpu_datamem_valid,
    output logic [NRV32_DATA_W-1:0] datamem_cpu_rdata,
    output logic                    datamem_cpu_ready
);

    localparam int unsigned            IDX_W      = $clog2(MEM_DEPTH_WORDS);
    localparam logic [NRV32_ADDR_W-1:0] SPAN_BYTES = NRV32_ADDR_W'(MEM_DEPTH_WORDS * 4);
    localparam logic [DMR_CNT_W-1:0]    CNT_LOAD   =
        DMR_CNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    dmr_state_e              state, state_next;
    logic [DMR_CNT_W-1:0]    cnt, cnt_next;
    logic                    lat_load_c;
    dmr_req_t                req_live, lat_req, req_c;
    logic [NRV32_ADDR_W-1:0] offset_c;
    logic                    in_range_c;
    logic                    ram_en_c;
    logic [NRV32_DATA_W-1:0] ram_q;
    logic                    rd_ok;

    assign req_live = '{addr: cpu_datamem_addr, wdata: cpu_datamem_wdata,
                        bytesel: cpu_datamem_bytesel};

    // From IDLE the request is not latched yet, so the live bus is used directly.
    assign req_c      = (state == NRV32_DMR_IDLE) ? req_live : lat_req;
    assign offset_c   = req_c.addr - BASE_ADDR;
    assign in_range_c = (offset_c < SPAN_BYTES);
    assign ram_en_c   = rst_n && (state_next == NRV32_DMR_RESP) && in_range_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NRV32_DMR_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        lat_load_c = 1'b0;
        case (state)
            NRV32_DMR_IDLE: begin
                if (cpu_datamem_valid) begin
                    lat_load_c = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_next = NRV32_DMR_WAIT;
                        cnt_next   = CNT_LOAD;
                    end else begin
                        state_next = NRV32_DMR_RESP;
                    end
                end
            end
            NRV32_DMR_WAIT: begin
                // A dropped valid is a protocol violation: abandon without touching the array.
                if (!cpu_datamem_valid) begin
                    state_next = NRV32_DMR_IDLE;
                    cnt_next   = '0;
                end else if (cnt == '0) begin
                    state_next = NRV32_DMR_RESP;
                end else begin
                    cnt_next = cnt - DMR_CNT_W'(1);
                end
            end
            NRV32_DMR_RESP: state_next = NRV32_DMR_IDLE;
            default:        state_next = NRV32_DMR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_req <= '0;
        end else if (lat_load_c) begin
            lat_req <= req_live;
        end
    end

    // Ready and rdata follow the RESP cycle by one edge; rdata is forced to zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ok             <= 1'b0;
            datamem_cpu_ready <= 1'b0;
            datamem_cpu_rdata <= '0;
        end else begin
            rd_ok             <= ram_en_c && (req_c.bytesel == '0);
            datamem_cpu_ready <= (state == NRV32_DMR_RESP);
            datamem_cpu_rdata <= ((state == NRV32_DMR_RESP) && rd_ok) ? ram_q : '0;
        end
    end

    nanorv32_ram_1p #(
        .DEPTH (MEM_DEPTH_WORDS),
        .AW    (IDX_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en_c),
        .we    (req_c.bytesel),
        .addr  (offset_c[IDX_W+1:2]),
        .wdata (req_c.wdata),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_nanorv32_datamem_resp.sv
// Scoreboard bench for nanorv32_datamem_resp: a zero-wait-state and a three-wait-state instance.
module tb_nanorv32_datamem_resp;

    localparam logic [31:0] B0 = 32'h0000_0000;
    localparam logic [31:0] B3 = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr, wdata;
    logic [3:0]  bytesel;
    logic        valid0, valid3;
    logic [31:0] rdata0, rdata3;
    logic        ready0, ready3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q [$];
    logic [31:0] mem0 [int];
    logic [31:0] mem3 [int];

    always #5 clk = ~clk;

    nanorv32_datamem_resp #(
        .MEM_DEPTH_WORDS (1024),
        .WAIT_STATES     (0),
        .BASE_ADDR       (B0)
    ) dut0 (
        .clk                 (clk),
        .rst_n               (rst_n),
        .cpu_datamem_addr    (addr),
        .cpu_datamem_wdata   (wdata),
        .cpu_datamem_bytesel (bytesel),
        .cpu_datamem_valid   (valid0),
        .datamem_cpu_rdata   (rdata0),
        .datamem_cpu_ready   (ready0)
    );

    nanorv32_datamem_resp #(
        .MEM_DEPTH_WORDS (1024),
        .WAIT_STATES     (3),
        .BASE_ADDR       (B3)
    ) dut3 (
        .clk                 (clk),
        .rst_n               (rst_n),
        .cpu_datamem_addr    (addr),
        .cpu_datamem_wdata   (wdata),
        .cpu_datamem_bytesel (bytesel),
        .cpu_datamem_valid   (valid3),
        .datamem_cpu_rdata   (rdata3),
        .datamem_cpu_ready   (ready3)
    );

    // Reference memory: applies a transfer and returns the rdata the bus should show.
    function automatic logic [31:0] model_xfer(input int sel, input logic [31:0] a,
                                               input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] base;
        logic [31:0] old;
        int          idx;
        base = (sel == 0) ? B0 : B3;
        if (a < base || a >= base + 32'h1000) return 32'h0;
        idx = int'((a - base) >> 2);
        if (sel == 0) old = mem0.exists(idx) ? mem0[idx] : 32'h0;
        else          old = mem3.exists(idx) ? mem3[idx] : 32'h0;
        if (be == 4'h0) return old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) old[8*i +: 8] = wd[8*i +: 8];
        end
        if (sel == 0) mem0[idx] = old;
        else          mem3[idx] = old;
        return 32'h0;
    endfunction

    // Drives one request from a negedge and waits (bounded) for ready; lat=0 on timeout.
    task automatic issue(input int sel, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output int lat, output logic [31:0] rd);
        addr = a; wdata = wd; bytesel = be;
        if (sel == 0) valid0 = 1'b1; else valid3 = 1'b1;
        lat = 0;
        rd  = 32'hxxxx_xxxx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (((sel == 0) ? ready0 : ready3) === 1'b1) begin
                lat = c;
                rd  = (sel == 0) ? rdata0 : rdata3;
                break;
            end
        end
        valid0 = 1'b0;
        valid3 = 1'b0;
    endtask

    task automatic test_reset();
        bit seen;
        rst_n = 1'b0; valid0 = 1'b0; valid3 = 1'b0;
        addr = '0; wdata = '0; bytesel = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ready0 !== 1'b0 || rdata0 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_dut0: ready=%b rdata=%h, want 0/00000000", ready0, rdata0);
        end
        n_checks++;
        if (ready3 !== 1'b0 || rdata3 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_dut3: ready=%b rdata=%h, want 0/00000000", ready3, rdata3);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ready0 !== 1'b0 || ready3 !== 1'b0 || rdata0 !== 32'h0 || rdata3 !== 32'h0)
                seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL reset_release_idle: ready/rdata became active with valid low, want quiet");
        end
    endtask

    task automatic test_word_rw();
        logic [31:0] ta [6] = '{32'h10, 32'h10, 32'h10, 32'h10, 32'hFFC, 32'hFFC};
        logic [31:0] tw [6] = '{32'hDEADBEEF, 32'h0, 32'h11223344, 32'h0, 32'hA5A55A5A, 32'h0};
        logic [3:0]  tb [6] = '{4'hF, 4'h0, 4'b0101, 4'h0, 4'hF, 4'h0};
        int          lat;
        logic [31:0] rd, exp;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(model_xfer(0, ta[i], tw[i], tb[i]));
            issue(0, ta[i], tw[i], tb[i], lat, rd);
            exp = exp_q.pop_front();
            n_checks++;
            if (lat !== 2) begin
                n_fail++;
                $display("FAIL word_rw_latency[%0d]: got %0d cycles, want 2", i, lat);
            end
            n_checks++;
            if (rd !== exp) begin
                n_fail++;
                $display("FAIL word_rw_rdata[%0d]: got %h, want %h", i, rd, exp);
            end
        end
        @(negedge clk);
        n_checks++;
        if (ready0 !== 1'b0 || rdata0 !== 32'h0) begin
            n_fail++;
            $display("FAIL word_rw_pulse_width: ready=%b rdata=%h after pulse, want 0/00000000",
                     ready0, rdata0);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] ta [4] = '{32'h0, 32'h1000, 32'h1000, 32'h0};
        logic [31:0] tw [4] = '{32'h0BADF00D, 32'hFFFFFFFF, 32'h0, 32'h0};
        logic [3:0]  tb [4] = '{4'hF, 4'hF, 4'h0, 4'h0};
        int          lat;
        logic [31:0] rd, exp;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(model_xfer(0, ta[i], tw[i], tb[i]));
            issue(0, ta[i], tw[i], tb[i], lat, rd);
            exp = exp_q.pop_front();
            n_checks++;
            if (lat !== 2 || rd !== exp) begin
                n_fail++;
                $display("FAIL oor[%0d]: got lat=%0d rdata=%h, want lat=2 rdata=%h", i, lat, rd, exp);
            end
        end
    endtask

    task automatic test_reset_in_ready();
        logic [31:0] exp;
        bit          got;
        exp_q.push_back(model_xfer(0, 32'h10, 32'h0, 4'h0));
        addr = 32'h10; wdata = '0; bytesel = 4'h0; valid0 = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ready0 === 1'b1) begin got = 1'b1; break; end
        end
        valid0 = 1'b0;
        exp = exp_q.pop_front();
        n_checks++;
        if (!got || rdata0 !== exp) begin
            n_fail++;
            $display("FAIL rst_ready_pre: seen=%0d rdata=%h, want 1/%h", got, rdata0, exp);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ready0 !== 1'b0 || rdata0 !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_ready_async: ready=%b rdata=%h, want 0/00000000", ready0, rdata0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_wait_states();
        logic [31:0] ta [3] = '{B3 + 32'h20, B3 + 32'h20, B3 - 32'h4};
        logic [31:0] tw [3] = '{32'h12345678, 32'h0, 32'h0};
        logic [3:0]  tb [3] = '{4'hF, 4'h0, 4'h0};
        int          lat;
        logic [31:0] rd, exp;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(model_xfer(1, ta[i], tw[i], tb[i]));
            issue(1, ta[i], tw[i], tb[i], lat, rd);
            exp = exp_q.pop_front();
            n_checks++;
            if (lat !== 5) begin
                n_fail++;
                $display("FAIL ws3_latency[%0d]: got %0d cycles, want 5", i, lat);
            end
            n_checks++;
            if (rd !== exp) begin
                n_fail++;
                $display("FAIL ws3_rdata[%0d]: got %h, want %h", i, rd, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          pulses;
        bit          extra;
        logic [31:0] exp;
        addr = B3 + 32'h20; wdata = '0; bytesel = 4'h0; valid3 = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back(model_xfer(1, addr, 32'h0, 4'h0));
        pulses = 0;
        for (int c = 1; c <= 30 && pulses < 3; c++) begin
            @(negedge clk);
            if (ready3 === 1'b1) begin
                pulses++;
                exp = exp_q.pop_front();
                n_checks++;
                if (c != 5 * pulses || rdata3 !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_pulse[%0d]: at cycle %0d rdata=%h, want cycle %0d rdata=%h",
                             pulses, c, rdata3, 5 * pulses, exp);
                end
                if (pulses == 3) valid3 = 1'b0;
            end
        end
        valid3 = 1'b0;
        n_checks++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d pulses, want 3", pulses);
        end
        extra = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ready3 !== 1'b0) extra = 1'b1;
        end
        n_checks++;
        if (extra) begin
            n_fail++;
            $display("FAIL b2b_tail: ready after valid dropped, want none");
        end
        exp_q.delete();
    endtask

    task automatic test_abort_and_reset();
        bit          seen;
        int          lat;
        logic [31:0] rd, exp;
        // Drop valid mid-WAIT on a write
        addr = B3 + 32'h20; wdata = 32'hCAFEF00D; bytesel = 4'hF; valid3 = 1'b1;
        repeat (2) @(negedge clk);
        valid3 = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ready3 !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL abort_no_ready: ready pulsed after abort, want none");
        end
        exp_q.push_back(model_xfer(1, B3 + 32'h20, 32'h0, 4'h0));
        issue(1, B3 + 32'h20, 32'h0, 4'h0, lat, rd);
        exp = exp_q.pop_front();
        n_checks++;
        if (lat !== 5 || rd !== exp) begin
            n_fail++;
            $display("FAIL abort_readback: got lat=%0d rdata=%h, want lat=5 rdata=%h", lat, rd, exp);
        end
        // Reset mid-WAIT on a write
        addr = B3 + 32'h20; wdata = 32'h55555555; bytesel = 4'hF; valid3 = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ready3 !== 1'b0 || rdata3 !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_wait_outputs: ready=%b rdata=%h, want 0/00000000", ready3, rdata3);
        end
        valid3 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ready3 !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL rst_wait_idle: ready pulsed after reset release, want none");
        end
        exp_q.push_back(model_xfer(1, B3 + 32'h20, 32'h0, 4'h0));
        issue(1, B3 + 32'h20, 32'h0, 4'h0, lat, rd);
        exp = exp_q.pop_front();
        n_checks++;
        if (lat !== 5 || rd !== exp) begin
            n_fail++;
            $display("FAIL rst_wait_readback: got lat=%0d rdata=%h, want lat=5 rdata=%h", lat, rd, exp);
        end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_out_of_range();
        test_reset_in_ready();
        test_wait_states();
        test_back_to_back();
        test_abort_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
